// File: rtl/partition_sweep_ctrl.sv
// Purpose: exhaustive on-chip sweep of one partition pair, accumulating exact-vs-approx error metrics.
// Latency: each pattern is held SETTLE+1 cycles; a sweep takes 2^IN_W*(SETTLE+1) busy cycles plus one done cycle.
// Backpressure: none; start is taken only in IDLE, and abort returns to IDLE at once, keeping partial metrics.
module partition_sweep_ctrl #(
    parameter int IN_W   = 7,
    parameter int OUT_W  = 4,
    parameter int SETTLE = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            abort,
    output logic [IN_W-1:0]                 pi,
    input  logic [OUT_W-1:0]                po_exact,
    input  logic [OUT_W-1:0]                po_approx,
    output logic                            busy,
    output logic                            done,
    output logic [IN_W:0]                   err_count,
    output logic [IN_W+$clog2(OUT_W):0]     hd_sum,
    output logic [OUT_W-1:0]                max_err
);

    localparam int EC_W  = IN_W + 1;
    localparam int HD_W  = IN_W + $clog2(OUT_W) + 1;
    localparam int PC_W  = $clog2(OUT_W + 1);
    localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HOLD   = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_FIN    = 2'd3;

    // With no settle time the sweep never visits HOLD.
    localparam logic [1:0]       S_NEXT   = (SETTLE == 0) ? S_SAMPLE : S_HOLD;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state;
    logic [CNT_W-1:0] settle_cnt;

    logic [OUT_W-1:0] diff_x;
    logic [PC_W-1:0]  diff_pop;
    logic [OUT_W:0]   diff_s;
    logic [OUT_W:0]   diff_neg;
    logic [OUT_W-1:0] diff_mag;
    logic             mism;

    // Per-pattern comparison: popcount of the xor and unsigned magnitude of the difference.
    always_comb begin
        diff_x   = po_exact ^ po_approx;
        diff_pop = '0;
        for (int i = 0; i < OUT_W; i++) begin
            diff_pop = diff_pop + PC_W'(diff_x[i]);
        end
        diff_s   = {1'b0, po_exact} - {1'b0, po_approx};
        diff_neg = '0 - diff_s;
        diff_mag = diff_s[OUT_W] ? diff_neg[OUT_W-1:0] : diff_s[OUT_W-1:0];
        mism     = |diff_x;
    end

    // Sweep sequencer: pattern counter, settle counter, status flags and metric accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pi         <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_count  <= '0;
            hd_sum     <= '0;
            max_err    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // abort has priority over a simultaneous start
                    if (start && !abort) begin
                        err_count  <= '0;
                        hd_sum     <= '0;
                        max_err    <= '0;
                        pi         <= '0;
                        settle_cnt <= CNT_LOAD;
                        busy       <= 1'b1;
                        state      <= S_NEXT;
                    end
                end
                S_HOLD: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_ONE;
                        if (settle_cnt == CNT_ONE) begin
                            state <= S_SAMPLE;
                        end
                    end
                end
                S_SAMPLE: begin
                    // an abort on the sampling edge discards this pattern
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        err_count <= err_count + EC_W'(mism);
                        hd_sum    <= hd_sum + HD_W'(diff_pop);
                        if (diff_mag > max_err) begin
                            max_err <= diff_mag;
                        end
                        if (&pi) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            pi         <= pi + IN_W'(1);
                            settle_cnt <= CNT_LOAD;
                            state      <= S_NEXT;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
